// File: rtl/led_sequence_player_pkg.sv
// Shared types and helpers for the Genius LED sequence player.
//   color_t        : 2-bit color code carried in the sequence memory
//   player_state_t : playback FSM states
//   SpeedSlow/Fast : encoding of the speed select input
package led_sequence_player_pkg;

    localparam int unsigned ColorW  = 2;
    localparam int unsigned NumLeds = 4;

    typedef enum logic [ColorW-1:0] {
        ColorRed    = 2'd0,
        ColorGreen  = 2'd1,
        ColorBlue   = 2'd2,
        ColorYellow = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StOn,
        StGap,
        StFlash,
        StDone
    } player_state_t;

    localparam logic SpeedSlow = 1'b0;
    localparam logic SpeedFast = 1'b1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold a down-count starting at max_cycles-1 (never zero width).
    function automatic int unsigned timer_width(input int unsigned max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/led_sequence_player_color_decoder.sv
// Color code to one-hot LED vector. Also used by the player-button echo path.
//   color_i : color code
//   leds_o  : one-hot LED vector, bit 0 red, 1 green, 2 blue, 3 yellow
module led_sequence_player_color_decoder
    import led_sequence_player_pkg::*;
(
    input  color_t             color_i,
    output logic [NumLeds-1:0] leds_o
);

    always_comb begin
        leds_o = '0;
        unique case (color_i)
            ColorRed:    leds_o = 4'b0001;
            ColorGreen:  leds_o = 4'b0010;
            ColorBlue:   leds_o = 4'b0100;
            ColorYellow: leds_o = 4'b1000;
        endcase
    end

endmodule

// File: rtl/led_sequence_player.sv
// Playback engine: reads color items 0..last_index from the sequence memory and shows
// each on its LED for the speed-dependent on time, followed by a dark gap. Also plays
// the all-LEDs flash used as failure/win indicator.
//   clk, rst_n          : clock, asynchronous active-low reset
//   play_start_i        : one-cycle request to play items 0..last_index_i
//   last_index_i        : last item index, sampled with play_start_i
//   speed_i             : 0 slow, 1 fast, sampled with play_start_i
//   flash_all_i         : one-cycle request to flash all LEDs (wins over play_start_i)
//   mem_rd_o, addr_o    : sequence memory read strobe and address
//   sequence_item_i     : memory read data, valid the cycle after mem_rd_o
//   led_*_o             : LED drives
//   busy_o              : high whenever not idle
//   play_done_o         : one-cycle pulse after a playback or a flash
// All outputs decode only from registers, so nothing is combinational from inputs.
module led_sequence_player #(
    parameter int unsigned COLOR_CODEFY_W = 2,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned SLOW_ON_CYCLES = 50_000_000,
    parameter int unsigned FAST_ON_CYCLES = 20_000_000,
    parameter int unsigned GAP_CYCLES     = 10_000_000,
    parameter int unsigned FLASH_CYCLES   = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      play_start_i,
    input  logic [ADDR_WIDTH-1:0]     last_index_i,
    input  logic                      speed_i,
    input  logic                      flash_all_i,
    output logic                      mem_rd_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    input  logic [COLOR_CODEFY_W-1:0] sequence_item_i,
    output logic                      led_red_o,
    output logic                      led_green_o,
    output logic                      led_blue_o,
    output logic                      led_yellow_o,
    output logic                      busy_o,
    output logic                      play_done_o
);

    import led_sequence_player_pkg::*;

    localparam int unsigned MaxCycles =
        max2(max2(SLOW_ON_CYCLES, FAST_ON_CYCLES), max2(GAP_CYCLES, FLASH_CYCLES));
    localparam int unsigned TimerW = timer_width(MaxCycles);

    // The timer counts down to zero, so a state of N cycles loads N-1.
    localparam logic [TimerW-1:0] SlowLoad  = TimerW'(SLOW_ON_CYCLES - 1);
    localparam logic [TimerW-1:0] FastLoad  = TimerW'(FAST_ON_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLoad   = TimerW'(GAP_CYCLES - 1);
    localparam logic [TimerW-1:0] FlashLoad = TimerW'(FLASH_CYCLES - 1);

    player_state_t         state_q;
    logic [TimerW-1:0]     timer_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic                  speed_q;
    color_t                color_q;
    logic                  timer_done;
    logic [NumLeds-1:0]    color_leds;
    logic [NumLeds-1:0]    leds;

    assign timer_done = (timer_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            index_q <= '0;
            last_q  <= '0;
            speed_q <= SpeedSlow;
            color_q <= ColorRed;
        end else begin
            case (state_q)
                StIdle: begin
                    if (flash_all_i) begin
                        timer_q <= FlashLoad;
                        state_q <= StFlash;
                    end else if (play_start_i) begin
                        last_q  <= last_index_i;
                        speed_q <= speed_i;
                        index_q <= '0;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    color_q <= color_t'(sequence_item_i);
                    timer_q <= (speed_q == SpeedFast) ? FastLoad : SlowLoad;
                    state_q <= StOn;
                end
                StOn: begin
                    if (timer_done) begin
                        timer_q <= GapLoad;
                        state_q <= StGap;
                    end else begin
                        timer_q <= timer_q - TimerW'(1);
                    end
                end
                StGap: begin
                    if (timer_done) begin
                        // End check before the increment so last index 31 never wraps.
                        if (index_q == last_q) begin
                            state_q <= StDone;
                        end else begin
                            index_q <= index_q + ADDR_WIDTH'(1);
                            state_q <= StFetch;
                        end
                    end else begin
                        timer_q <= timer_q - TimerW'(1);
                    end
                end
                StFlash: begin
                    if (timer_done) begin
                        state_q <= StDone;
                    end else begin
                        timer_q <= timer_q - TimerW'(1);
                    end
                end
                StDone: begin
                    // Clear so the address reads zero while idle.
                    index_q <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    led_sequence_player_color_decoder u_color_decoder (
        .color_i (color_q),
        .leds_o  (color_leds)
    );

    always_comb begin
        leds = '0;
        case (state_q)
            StOn:    leds = color_leds;
            StFlash: leds = '1;
            default: leds = '0;
        endcase
    end

    assign mem_rd_o    = (state_q == StFetch);
    assign addr_o      = index_q;
    assign busy_o      = (state_q != StIdle);
    assign play_done_o = (state_q == StDone);

    assign led_red_o    = leds[0];
    assign led_green_o  = leds[1];
    assign led_blue_o   = leds[2];
    assign led_yellow_o = leds[3];

endmodule

// File: tb/tb_led_sequence_player.sv
module tb_led_sequence_player;

    localparam int SlowOn  = 8;
    localparam int FastOn  = 4;
    localparam int GapCyc  = 2;
    localparam int FlashOn = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       play_start;
    logic [4:0] last_index;
    logic       speed;
    logic       flash_all;
    logic       mem_rd;
    logic [4:0] addr;
    logic [1:0] seq_item;
    logic       led_red, led_green, led_blue, led_yellow;
    logic       busy, play_done;

    logic [1:0] mem [32];
    int         cyc;
    int         n_vec;
    int         n_err;

    led_sequence_player #(
        .COLOR_CODEFY_W (2),
        .ADDR_WIDTH     (5),
        .SLOW_ON_CYCLES (SlowOn),
        .FAST_ON_CYCLES (FastOn),
        .GAP_CYCLES     (GapCyc),
        .FLASH_CYCLES   (FlashOn)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .play_start_i    (play_start),
        .last_index_i    (last_index),
        .speed_i         (speed),
        .flash_all_i     (flash_all),
        .mem_rd_o        (mem_rd),
        .addr_o          (addr),
        .sequence_item_i (seq_item),
        .led_red_o       (led_red),
        .led_green_o     (led_green),
        .led_blue_o      (led_blue),
        .led_yellow_o    (led_yellow),
        .busy_o          (busy),
        .play_done_o     (play_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) seq_item <= mem[addr];
    end

    // Packed view: {mem_rd, addr[4:0], yellow, blue, green, red, busy, play_done}
    function automatic logic [11:0] observed();
        return {mem_rd, addr, led_yellow, led_blue, led_green, led_red, busy, play_done};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle k is the cycle following the k-th clock edge after play_start is sampled.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Expected outputs during a playback: each item is FETCH, LOAD, on time, gap.
    function automatic logic [11:0] expect_play(input int c, input int last, input int on,
                                                input int total);
        int         per;
        int         k;
        int         off;
        logic       rd;
        logic [4:0] a;
        logic [3:0] l;
        per = 2 + on + GapCyc;
        if (c >= 1 && c <= total) begin
            k   = (c - 1) / per;
            off = (c - 1) % per;
            rd  = (off == 0);
            a   = 5'(k);
            l   = (off >= 2 && off < 2 + on) ? (4'b0001 << mem[k]) : 4'b0000;
            return {rd, a, l, 1'b1, 1'b0};
        end
        if (c == total + 1) return {1'b0, 5'(last), 4'b0000, 1'b1, 1'b1};
        return 12'h000;
    endfunction

    task automatic run_play(input string name, input int last, input logic spd, input bit poke,
                            output int pulses, output int dones);
        int         on;
        int         total;
        logic [3:0] prev_l;
        logic [3:0] cur_l;
        on     = spd ? FastOn : SlowOn;
        total  = (2 + on + GapCyc) * (last + 1);
        pulses = 0;
        dones  = 0;
        prev_l = 4'b0000;
        play_start = 1'b1;
        last_index = 5'(last);
        speed      = spd;
        cyc = 0;
        tick();
        play_start = 1'b0;
        while (cyc <= total + 2) begin
            check_eq($sformatf("%s c%0d", name, cyc), 32'(observed()),
                     32'(expect_play(cyc, last, on, total)));
            cur_l = {led_yellow, led_blue, led_green, led_red};
            if (cur_l != 4'b0000 && prev_l == 4'b0000) pulses++;
            prev_l = cur_l;
            if (play_done) dones++;
            if (poke) begin
                // Requests and setting changes while busy must be ignored.
                if (cyc == 5) begin
                    play_start = 1'b1;
                    speed      = ~spd;
                    last_index = 5'd0;
                end
                if (cyc == 6)  play_start = 1'b0;
                if (cyc == 12) flash_all = 1'b1;
                if (cyc == 13) flash_all = 1'b0;
            end
            tick();
        end
        play_start = 1'b0;
        flash_all  = 1'b0;
        speed      = 1'b0;
        last_index = 5'd0;
    endtask

    initial begin
        int pulses;
        int dones;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        play_start = 1'b0;
        last_index = 5'd0;
        speed      = 1'b0;
        flash_all  = 1'b0;
        seq_item   = 2'd0;
        for (int i = 0; i < 32; i++) mem[i] = 2'(i);

        // Reset and idle
        @(negedge clk);
        check_eq("reset_held", 32'(observed()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("idle%0d", i), 32'(observed()), 32'h0);
        end

        // Fast play of {blue, red, yellow} with ignored requests while busy
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
        run_play("fast", 2, 1'b1, 1'b1, pulses, dones);
        check_eq("fast_pulses", 32'(pulses), 32'd3);
        check_eq("fast_dones", 32'(dones), 32'd1);
        tick();
        check_eq("fast_idle", 32'(observed()), 32'h0);

        // Slow single green item: on cycles 3..10, done at 13
        mem[0] = 2'd1;
        run_play("slow", 0, 1'b0, 1'b0, pulses, dones);
        check_eq("slow_pulses", 32'(pulses), 32'd1);

        // Flash and play_start together: flash wins, no memory access
        flash_all  = 1'b1;
        play_start = 1'b1;
        last_index = 5'd2;
        speed      = 1'b1;
        cyc = 0;
        tick();
        flash_all  = 1'b0;
        play_start = 1'b0;
        while (cyc <= 8) begin
            check_eq($sformatf("flash c%0d", cyc), 32'(observed()),
                     (cyc <= FlashOn) ? 32'h03e : (cyc == FlashOn + 1) ? 32'h003 : 32'h000);
            tick();
        end

        // Reset during ON of item 1 (red, cycles 11..14)
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
        play_start = 1'b1;
        last_index = 5'd2;
        speed      = 1'b1;
        cyc = 0;
        tick();
        play_start = 1'b0;
        while (cyc < 12) tick();
        check_eq("pre_rst_red", 32'(observed()), {20'h0, 1'b0, 5'd1, 4'b0001, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", 32'(observed()), 32'h0);
        tick();
        tick();
        check_eq("rst_hold", 32'(observed()), 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_idle", 32'(observed()), 32'h0);
        run_play("restart", 0, 1'b1, 1'b0, pulses, dones);
        check_eq("restart_dones", 32'(dones), 32'd1);

        // Full length: 32 items, addr 0..31, no wrap
        for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
        run_play("full", 31, 1'b1, 1'b0, pulses, dones);
        check_eq("full_pulses", 32'(pulses), 32'd32);
        check_eq("full_dones", 32'(dones), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
